// File: rtl/dcache_if.sv
// Datapath-side and memory-side signals of the data cache.
// The slave modport is the cache's view; master is the datapath/memory environment.
`timescale 1ns/1ps
interface dcache_if;
  logic        halt;
  logic        dmemREN;
  logic        dmemWEN;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  logic        dhit;
  logic [31:0] dmemload;
  logic        flushed;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] dload;
  logic        dwait;

  modport slave (
    input  halt, dmemREN, dmemWEN, dmemaddr, dmemstore, dload, dwait,
    output dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
  );

  modport master (
    output halt, dmemREN, dmemWEN, dmemaddr, dmemstore, dload, dwait,
    input  dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
  );
endinterface

// File: rtl/dcache.sv
// Direct-mapped, 16-set, one-word-per-line write-back data cache with
// halt-triggered flush that finally writes the hit count to 0x3100.
`timescale 1ns/1ps
module dcache (
  input  logic     CLK,
  input  logic     nRST,
  dcache_if.slave  dcif
);
  typedef enum logic [2:0] {IDLE, WB, FETCH, FLUSH, CNT, HALTED} state_t;

  state_t      state, nextState;
  logic [15:0] valid, dirty;
  logic [25:0] tags [16];
  logic [31:0] data [16];
  logic [3:0]  flushIdx;
  logic [31:0] hitCount;

  logic [3:0]  idx;
  logic [25:0] reqTag;
  logic        req, hit, victimDirty, flushDirty;
  logic        fill, flushStep, flushClean;

  assign idx         = dcif.dmemaddr[5:2];
  assign reqTag      = dcif.dmemaddr[31:6];
  assign req         = dcif.dmemREN | dcif.dmemWEN;
  assign hit         = req & valid[idx] & (tags[idx] == reqTag) & ~dcif.halt;
  assign victimDirty = valid[idx] & dirty[idx];
  assign flushDirty  = valid[flushIdx] & dirty[flushIdx];

  always_comb begin
    nextState     = state;
    dcif.dhit     = 1'b0;
    dcif.dmemload = '0;
    dcif.flushed  = 1'b0;
    dcif.dREN     = 1'b0;
    dcif.dWEN     = 1'b0;
    dcif.daddr    = '0;
    dcif.dstore   = '0;
    fill          = 1'b0;
    flushStep     = 1'b0;
    flushClean    = 1'b0;
    case (state)
      IDLE: begin
        if (dcif.halt) begin
          nextState = FLUSH;
        end else if (hit) begin
          dcif.dhit = 1'b1;
          // Simultaneous read and write is served as a write, so no load data.
          if (!dcif.dmemWEN) dcif.dmemload = data[idx];
        end else if (req) begin
          nextState = victimDirty ? WB : FETCH;
        end
      end
      WB: begin
        dcif.dWEN   = 1'b1;
        dcif.daddr  = {tags[idx], idx, 2'b00};
        dcif.dstore = data[idx];
        if (!dcif.dwait) nextState = FETCH;
      end
      FETCH: begin
        dcif.dREN  = 1'b1;
        dcif.daddr = {dcif.dmemaddr[31:2], 2'b00};
        if (!dcif.dwait) begin
          fill      = 1'b1;
          nextState = IDLE;
        end
      end
      FLUSH: begin
        if (flushDirty) begin
          dcif.dWEN   = 1'b1;
          dcif.daddr  = {tags[flushIdx], flushIdx, 2'b00};
          dcif.dstore = data[flushIdx];
          if (!dcif.dwait) begin
            flushClean = 1'b1;
            flushStep  = 1'b1;
          end
        end else begin
          flushStep = 1'b1;
        end
        if (flushStep && flushIdx == 4'd15) nextState = CNT;
      end
      CNT: begin
        dcif.dWEN   = 1'b1;
        dcif.daddr  = 32'h0000_3100;
        dcif.dstore = hitCount;
        if (!dcif.dwait) nextState = HALTED;
      end
      HALTED: begin
        dcif.flushed = 1'b1;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      flushIdx <= '0;
      hitCount <= '0;
    end else begin
      state <= nextState;
      if (state == IDLE && dcif.halt) flushIdx <= '0;
      else if (flushStep)             flushIdx <= flushIdx + 4'd1;
      if (dcif.dhit) hitCount <= hitCount + 32'd1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid <= '0;
      dirty <= '0;
    end else begin
      if (fill) begin
        valid[idx] <= 1'b1;
        dirty[idx] <= 1'b0;
      end else if (dcif.dhit && dcif.dmemWEN) begin
        dirty[idx] <= 1'b1;
      end
      if (flushClean) dirty[flushIdx] <= 1'b0;
    end
  end

  // Tag/data need no reset: they are meaningless while valid is clear.
  always_ff @(posedge CLK) begin
    if (fill) begin
      tags[idx] <= reqTag;
      data[idx] <= dcif.dload;
    end else if (dcif.dhit && dcif.dmemWEN) begin
      data[idx] <= dcif.dmemstore;
    end
  end
endmodule

// File: tb/tb_dcache.sv
// Scoreboarded bench for dcache: a flat word-memory reference model predicts
// read data, flush contents and the final hit count.
`timescale 1ns/1ps
module tb_dcache;
  logic clk = 1'b0;
  logic nRST = 1'b0;
  always #5 clk = ~clk;

  dcache_if dif();
  dcache u_dut (.CLK(clk), .nRST(nRST), .dcif(dif));

  typedef struct {bit isRead; logic [31:0] data;} exp_t;
  typedef struct {bit isWr; logic [31:0] addr; logic [31:0] data;} xfer_t;

  int checks = 0;
  int errors = 0;
  exp_t  expQ[$];
  xfer_t memLog[$];
  logic [31:0] physMem [logic [31:0]];
  logic [31:0] refMem  [logic [31:0]];
  int fixedWait = 0;
  int waitLeft  = 0;
  int reqCount  = 0;
  exp_t  monE;
  xfer_t xf;

  function automatic logic [31:0] initVal(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction
  function automatic logic [31:0] physRd(logic [31:0] a);
    return physMem.exists(a) ? physMem[a] : initVal(a);
  endfunction
  function automatic logic [31:0] refRd(logic [31:0] a);
    return refMem.exists(a) ? refMem[a] : initVal(a);
  endfunction
  function automatic int pickWait();
    return (fixedWait >= 0) ? fixedWait : int'($urandom_range(0, 3));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Memory model: a transfer completes on an edge where its wait count is spent.
  always @(posedge clk) begin
    if (dif.dREN || dif.dWEN) begin
      if (waitLeft == 0) begin
        xf.isWr = dif.dWEN;
        xf.addr = dif.daddr;
        xf.data = dif.dWEN ? dif.dstore : physRd(dif.daddr);
        if (dif.dWEN) physMem[dif.daddr] = dif.dstore;
        memLog.push_back(xf);
        waitLeft = pickWait();
      end else begin
        waitLeft--;
      end
    end else begin
      waitLeft = pickWait();
    end
  end

  always @(negedge clk) begin
    dif.dwait = (waitLeft != 0);
    dif.dload = physRd(dif.daddr);
  end

  // Bus-rule monitor.
  always @(negedge clk) begin
    if (nRST) begin
      checks++;
      if ((dif.dREN && dif.dWEN) || (dif.daddr[1:0] != 2'b00) ||
          (!dif.dREN && !dif.dWEN && (dif.daddr != 0 || dif.dstore != 0)) ||
          (dif.flushed && (dif.dREN || dif.dWEN || dif.dhit))) begin
        errors++;
        $display("FAIL bus_rules: dREN=%b dWEN=%b daddr=%h dstore=%h flushed=%b dhit=%b, required legal bus",
                 dif.dREN, dif.dWEN, dif.daddr, dif.dstore, dif.flushed, dif.dhit);
      end
    end
  end

  // Scoreboard monitor: every dhit retires the oldest outstanding request.
  always @(negedge clk) begin
    if (nRST && dif.dhit) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_dhit: got dhit=1, required no outstanding hit");
      end else begin
        monE = expQ.pop_front();
        chk(monE.isRead ? "read_data" : "write_dmemload", dif.dmemload,
            monE.isRead ? monE.data : 32'h0);
      end
    end
  end

  task automatic doReq(input logic [31:0] a, input bit rd, input bit wr,
                       input logic [31:0] st, output int lat, output int renCyc);
    exp_t e;
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    lat = 0;
    renCyc = 0;
    @(posedge clk); #1;
    e.isRead = rd && !wr;
    e.data   = refRd(w);
    if (wr) refMem[w] = st;
    expQ.push_back(e);
    reqCount++;
    dif.dmemaddr = a; dif.dmemREN = rd; dif.dmemWEN = wr; dif.dmemstore = st;
    forever begin
      @(negedge clk);
      if (dif.dhit) break;
      if (dif.dREN && dif.daddr == w) renCyc++;
      lat++;
      if (lat > 500) begin
        checks++;
        errors++;
        $display("FAIL req_timeout: addr %h got no dhit in %0d cycles, required dhit", a, lat);
        break;
      end
    end
    @(posedge clk); #1;
    dif.dmemREN = 1'b0; dif.dmemWEN = 1'b0;
  endtask

  task automatic resetRelease();
    refMem.delete();
    foreach (physMem[k]) refMem[k] = physMem[k];
    expQ.delete();
    reqCount = 0;
    dif.halt = 1'b0;
    @(negedge clk);
    nRST = 1'b1;
  endtask

  task automatic haltAndWait(output bit ok);
    int n;
    ok = 1'b0;
    @(posedge clk); #1;
    dif.halt = 1'b1;
    for (n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (dif.flushed) begin ok = 1'b1; break; end
    end
    chk("flushed_reached", {31'b0, ok}, 32'h1);
  endtask

  initial begin
    int lat, ren, n;
    bit ok;
    logic [31:0] a;
    dif.halt = 1'b0; dif.dmemREN = 1'b1; dif.dmemWEN = 1'b0;
    dif.dmemaddr = 32'h0; dif.dmemstore = 32'h0;
    #12;
    chk("rst_dhit", {31'b0, dif.dhit}, 32'h0);
    chk("rst_dmemload", dif.dmemload, 32'h0);
    chk("rst_flushed", {31'b0, dif.flushed}, 32'h0);
    chk("rst_dREN", {31'b0, dif.dREN}, 32'h0);
    chk("rst_dWEN", {31'b0, dif.dWEN}, 32'h0);
    chk("rst_daddr", dif.daddr, 32'h0);
    chk("rst_dstore", dif.dstore, 32'h0);
    dif.dmemREN = 1'b0;
    @(negedge clk);
    nRST = 1'b1;

    // Reset in the middle of a stalled fill.
    fixedWait = 20;
    @(posedge clk); #1;
    dif.dmemaddr = 32'h2000; dif.dmemREN = 1'b1;
    for (n = 0; n < 5; n++) begin
      @(negedge clk);
      if (dif.dREN) break;
    end
    chk("fetch_started", {31'b0, dif.dREN}, 32'h1);
    #2 nRST = 1'b0;
    #1;
    chk("rst_mid_fetch_dREN", {31'b0, dif.dREN}, 32'h0);
    chk("rst_mid_fetch_daddr", dif.daddr, 32'h0);
    dif.dmemREN = 1'b0;
    fixedWait = 0;
    resetRelease();
    doReq(32'h2000, 1'b1, 1'b0, 32'h0, lat, ren);
    chk("refetch_after_reset_latency", lat, 2);

    // Cold read with three wait states, then a zero-wait re-read.
    fixedWait = 3;
    physMem[32'h40] = 32'hDEAD_BEEF;
    refMem[32'h40]  = 32'hDEAD_BEEF;
    doReq(32'h40, 1'b1, 1'b0, 32'h0, lat, ren);
    chk("cold_read_dREN_cycles", ren, 4);
    chk("cold_read_latency", lat, 5);
    doReq(32'h40, 1'b1, 1'b0, 32'h0, lat, ren);
    chk("warm_read_latency", lat, 0);

    // Dirty victim write-back before the conflicting fill.
    fixedWait = 0;
    doReq(32'h04, 1'b0, 1'b1, 32'h1111_1111, lat, ren);
    memLog.delete();
    doReq(32'h44, 1'b1, 1'b0, 32'h0, lat, ren);
    chk("wb_log_len", memLog.size(), 2);
    if (memLog.size() >= 2) begin
      chk("wb_is_write", {31'b0, memLog[0].isWr}, 32'h1);
      chk("wb_addr", memLog[0].addr, 32'h04);
      chk("wb_data", memLog[0].data, 32'h1111_1111);
      chk("wb_then_fetch", {31'b0, memLog[1].isWr}, 32'h0);
      chk("wb_fetch_addr", memLog[1].addr, 32'h44);
    end

    // Read and write together behave as a write.
    doReq(32'h08, 1'b1, 1'b0, 32'h0, lat, ren);
    doReq(32'h08, 1'b1, 1'b1, 32'h5, lat, ren);
    chk("rw_hit_latency", lat, 0);
    doReq(32'h08, 1'b1, 1'b0, 32'h0, lat, ren);

    // Randomized traffic over 64 words (4 tags per set), random wait states.
    fixedWait = -1;
    repeat (300) begin
      a = {24'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
      n = int'($urandom_range(0, 3));
      doReq(a, n != 2, n >= 2, $urandom, lat, ren);
    end
    chk("queue_drained", expQ.size(), 0);

    // Flush: memory must then hold every write, last transfer is the hit count.
    haltAndWait(ok);
    if (ok) begin
      chk("final_xfer_addr", memLog[$].addr, 32'h3100);
      chk("final_hit_count", memLog[$].data, reqCount);
      foreach (refMem[k]) chk("flushed_mem_word", physRd(k), refMem[k]);
    end
    dif.dmemREN = 1'b1;
    repeat (5) @(negedge clk);
    chk("halted_holds_flushed", {31'b0, dif.flushed}, 32'h1);
    dif.dmemREN = 1'b0;

    // Exact flush sequence: dirty sets 2 and 9, hit count 7.
    #2 nRST = 1'b0;
    fixedWait = 0;
    resetRelease();
    doReq(32'h08, 1'b0, 1'b1, 32'hA5A5_0002, lat, ren);
    doReq(32'h24, 1'b0, 1'b1, 32'hA5A5_0009, lat, ren);
    repeat (5) doReq(32'h08, 1'b1, 1'b0, 32'h0, lat, ren);
    memLog.delete();
    haltAndWait(ok);
    chk("flush_xfer_count", memLog.size(), 3);
    if (memLog.size() == 3) begin
      chk("flush0_addr", memLog[0].addr, 32'h08);
      chk("flush0_data", memLog[0].data, 32'hA5A5_0002);
      chk("flush1_addr", memLog[1].addr, 32'h24);
      chk("flush1_data", memLog[1].data, 32'hA5A5_0009);
      chk("flush2_addr", memLog[2].addr, 32'h3100);
      chk("flush2_count", memLog[2].data, 32'd7);
    end
    repeat (4) @(negedge clk);
    chk("halted_flushed_held", {31'b0, dif.flushed}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
